// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: streams words into IMEM, holds the core in reset
// for a flush window, then releases it. Define IMEM_LOADER_NOP_FILL_EN to pad unused IMEM with NOPs.
module imem_loader #(
  parameter int ADDR_W     = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              enable,
  output logic              busy,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
`ifdef IMEM_LOADER_NOP_FILL_EN
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`endif
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  localparam logic [ADDR_W-1:0] PTR_MAX    = '1;
  localparam logic [ADDR_W:0]   COUNT_MAX  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [3:0]        FLUSH_LAST = 4'(RST_CYCLES);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_word_count;
  logic              r_err;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_core_rst;
  logic              r_enable;
  logic [3:0]        r_flush_cnt;

  logic [2:0]        w_next_state;
  logic [2:0]        w_after_load;
  logic              w_accept;
  logic              w_start_load;
  logic              w_ptr_at_max;

  assign in_ready     = (r_state == S_LOAD);
  assign w_accept     = in_valid && in_ready;
  assign w_ptr_at_max = (r_ptr == PTR_MAX);
  assign w_start_load = start &&
                        ((r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_ERROR));
  assign busy         = !((r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_ERROR));

  // A program that already fills the whole memory has nothing left to pad.
`ifdef IMEM_LOADER_NOP_FILL_EN
  assign w_after_load = w_ptr_at_max ? S_FLUSH : S_FILL;
`else
  assign w_after_load = S_FLUSH;
`endif

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (start) w_next_state = S_LOAD;
      end
      S_LOAD: begin
        if (w_accept) begin
          if (in_last)           w_next_state = w_after_load;
          else if (w_ptr_at_max) w_next_state = S_ERROR;
        end
      end
`ifdef IMEM_LOADER_NOP_FILL_EN
      S_FILL: begin
        if (w_ptr_at_max) w_next_state = S_FLUSH;
      end
`endif
      // The flush window opens only once the final write strobe has dropped.
      S_FLUSH: begin
        if (!r_we && (r_flush_cnt == FLUSH_LAST)) w_next_state = S_RUN;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_word_count <= '0;
      r_err        <= 1'b0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_core_rst   <= 1'b1;
      r_enable     <= 1'b0;
      r_flush_cnt  <= '0;
    end else begin
      r_state    <= w_next_state;
      r_we       <= 1'b0;
      r_core_rst <= (w_next_state != S_RUN);
      r_enable   <= (w_next_state == S_RUN);

      if (w_start_load) begin
        r_ptr        <= '0;
        r_word_count <= '0;
        r_err        <= 1'b0;
      end

      if (w_accept) begin
        r_we    <= 1'b1;
        r_addr  <= r_ptr;
        r_wdata <= in_data;
        r_ptr   <= r_ptr + 1'b1;
        if (r_word_count != COUNT_MAX) r_word_count <= r_word_count + 1'b1;
        if (!in_last && w_ptr_at_max)  r_err        <= 1'b1;
      end

`ifdef IMEM_LOADER_NOP_FILL_EN
      if (r_state == S_FILL) begin
        r_we    <= 1'b1;
        r_addr  <= r_ptr;
        r_wdata <= NOP;
        r_ptr   <= r_ptr + 1'b1;
      end
`endif

      if ((w_next_state == S_FLUSH) && (r_state != S_FLUSH)) begin
        r_flush_cnt <= '0;
      end else if ((r_state == S_FLUSH) && !r_we) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign imem_we      = r_we;
  assign imem_addr    = r_addr;
  assign imem_wdata   = r_wdata;
  assign core_rst     = r_core_rst;
  assign enable       = r_enable;
  assign err_overflow = r_err;
  assign word_count   = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected IMEM writes go into a scoreboard queue and are
// popped as the write port strobes; control outputs are checked at fixed edge offsets.
module tb_imem_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int RC    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_last;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          enable;
  logic          busy;
  logic          err_overflow;
  logic [AW:0]   word_count;

  imem_loader #(.ADDR_W(AW), .RST_CYCLES(RC)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst     (core_rst),
    .enable       (enable),
    .busy         (busy),
    .err_overflow (err_overflow),
    .word_count   (word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           sb[$];
  wr_t           mon_e;
  int            total    = 0;
  int            bad      = 0;
  int            n_writes = 0;
  int            n0;
  logic [AW-1:0] exp_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b0 && imem_we === 1'b1) begin
      n_writes++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_write: observed addr %h data %h expected no write",
               imem_addr, imem_wdata);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(mon_e.addr));
        chk("wr_data", imem_wdata, mon_e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),     32'd0);
    chk({tag, "_imem_we"},   32'(imem_we),      32'd0);
    chk({tag, "_imem_addr"}, 32'(imem_addr),    32'd0);
    chk({tag, "_wdata"},     imem_wdata,        32'd0);
    chk({tag, "_core_rst"},  32'(core_rst),     32'd1);
    chk({tag, "_enable"},    32'(enable),       32'd0);
    chk({tag, "_busy"},      32'(busy),         32'd0);
    chk({tag, "_err"},       32'(err_overflow), 32'd0);
    chk({tag, "_count"},     32'(word_count),   32'd0);
  endtask

  task automatic start_load();
    start = 1'b1;
    step();
    start   = 1'b0;
    exp_ptr = '0;
  endtask

  // Drive one beat; the loader must be ready, so acceptance happens on the next edge.
  task automatic send(input logic [31:0] data, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    chk("send_ready", 32'(in_ready), 32'd1);
    sb.push_back(wr_t'({exp_ptr, data}));
    exp_ptr++;
    step();
  endtask

  // Called right after the edge accepting the last beat; checks release timing.
  task automatic finish_load(input string tag, input int nwords);
    int nfill;
    in_valid = 1'b0;
    in_last  = 1'b0;
    nfill    = 0;
`ifdef IMEM_LOADER_NOP_FILL_EN
    nfill = DEPTH - nwords;
    for (int a = nwords; a < DEPTH; a++) sb.push_back(wr_t'({AW'(a), 32'h0000_0013}));
`endif
    chk({tag, "_count"}, 32'(word_count), 32'(nwords));
    steps(nfill + RC + 1);
    chk({tag, "_enable_pre"},   32'(enable),   32'd0);
    chk({tag, "_core_rst_pre"}, 32'(core_rst), 32'd1);
    chk({tag, "_busy_pre"},     32'(busy),     32'd1);
    step();
    chk({tag, "_enable"},   32'(enable),   32'd1);
    chk({tag, "_core_rst"}, 32'(core_rst), 32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd0);
    chk({tag, "_nwrites"},  32'(n_writes - n0), 32'(nwords + nfill));
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    exp_ptr  = '0;

    // Reset state, during and after reset.
    steps(2);
    chk_reset("rst_held");
    rst = 1'b0;
    step();
    chk_reset("rst_rel");

    // Basic back-to-back load.
    start_load();
    chk("basic_busy",  32'(busy),     32'd1);
    chk("basic_ready", 32'(in_ready), 32'd1);
    n0 = n_writes;
    send(32'h00a0_0093, 1'b0);
    send(32'h0140_0113, 1'b0);
    send(32'h0020_81b3, 1'b1);
    finish_load("basic", 3);

    // Reload from RUN: enable drops and core_rst rises on the start edge.
    start = 1'b1;
    step();
    start   = 1'b0;
    exp_ptr = '0;
    chk("reload_enable",   32'(enable),     32'd0);
    chk("reload_core_rst", 32'(core_rst),   32'd1);
    chk("reload_ready",    32'(in_ready),   32'd1);
    chk("reload_count",    32'(word_count), 32'd0);

    // Backpressure: valid toggles 1,0,1,0,1.
    n0 = n_writes;
    send(32'h1111_0001, 1'b0);
    in_valid = 1'b0;
    step();
    send(32'h2222_0002, 1'b0);
    in_valid = 1'b0;
    step();
    send(32'h3333_0003, 1'b1);
    finish_load("bp", 3);

    // Overflow: five words into a four-word memory, last only on the fifth.
    start_load();
    n0 = n_writes;
    send(32'hA000_0000, 1'b0);
    send(32'hA000_0001, 1'b0);
    send(32'hA000_0002, 1'b0);
    send(32'hA000_0003, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hA000_0004;
    in_last  = 1'b1;
    chk("ovf_ready",    32'(in_ready),     32'd0);
    chk("ovf_err",      32'(err_overflow), 32'd1);
    chk("ovf_enable",   32'(enable),       32'd0);
    chk("ovf_core_rst", 32'(core_rst),     32'd1);
    chk("ovf_busy",     32'(busy),         32'd0);
    chk("ovf_count",    32'(word_count),   32'd4);
    steps(3);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("ovf_err_sticky", 32'(err_overflow),      32'd1);
    chk("ovf_nwrites",    32'(n_writes - n0),     32'd4);
    chk("ovf_sb_empty",   32'(sb.size()),         32'd0);
    start_load();
    chk("ovf_clear_err",   32'(err_overflow), 32'd0);
    chk("ovf_clear_count", 32'(word_count),   32'd0);
    chk("ovf_clear_ready", 32'(in_ready),     32'd1);

    // Mid-load reset after two accepted words; the second write never appears.
    n0 = n_writes;
    send(32'hB000_0000, 1'b0);
    send(32'hB000_0001, 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk_reset("midrst");
    sb.delete();
    step();
    chk("midrst_nwrites", 32'(n_writes - n0), 32'd1);
    rst = 1'b0;
    step();
    chk_reset("midrst_rel");

    // Program exactly filling memory: no overflow, no padding.
    start_load();
    n0 = n_writes;
    send(32'hC000_0000, 1'b0);
    send(32'hC000_0001, 1'b0);
    send(32'hC000_0002, 1'b0);
    send(32'hC000_0003, 1'b1);
    chk("full_err", 32'(err_overflow), 32'd0);
    finish_load("full", 4);

    steps(2);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
